traffic_phase_seq: RTL and testbench
====================================

// Module: traffic_phase_seq
// PURPOSE
//  Consumer of the six per-movement green durations produced by the key-adjust block.
//  Runs the intersection phase cycle on a seconds tick divided down from sys_clk.
//  Counts down each phase and drives the per-movement lamps and the remaining-time display value.
//  Phase order: EW_LEFT > EW_STRA > EW_RIGHT > EW_YEL > SN_LEFT > SN_STRA > SN_RIGHT > SN_YEL > repeat.
// PARAMETERS
//  TICK_DIV     50_000_000  sys_clk cycles per 1 s tick (>=2)
//  YELLOW_TIME  3           yellow phase length in ticks (1..63)
//  RST_TIME     10          remaining count loaded at reset (matches producer reset durations)
//  ALLRED_TIME  2           all-red clearance length in ticks (used only with ALL_RED_EN)
// PORTS
//  sys_clk        in   1  system clock, all logic on rising edge
//  sys_rst_n      in   1  synchronous active-low reset
//  ew_left_time   in   6  EW left-turn green duration, ticks
//  ew_stra_time   in   6  EW straight green duration, ticks
//  ew_right_time  in   6  EW right-turn green duration, ticks
//  sn_left_time   in   6  SN left-turn green duration, ticks
//  sn_stra_time   in   6  SN straight green duration, ticks
//  sn_right_time  in   6  SN right-turn green duration, ticks
//  ew_green       out  3  {left,stra,right} EW green lamps, one-hot or zero
//  ew_yellow      out  1  EW yellow lamp
//  ew_red         out  1  EW red lamp (=1 whenever EW has no green/yellow)
//  sn_green       out  3  {left,stra,right} SN green lamps
//  sn_yellow      out  1  SN yellow lamp
//  sn_red         out  1  SN red lamp
//  remain_time    out  6  ticks left in current phase, display value
//  phase          out  4  current state encoding (EW_LEFT=0 .. SN_YEL=7, ALLRED_EW=8, ALLRED_SN=9)
// BEHAVIOUR
//  - Reset (sys_rst_n=0 at posedge): prescaler=0, phase=EW_LEFT, remain_time=RST_TIME,
//    ew_green=3'b100, ew_yellow=0, ew_red=0, sn_green=0, sn_yellow=0, sn_red=1.
//  - Prescaler counts 0..TICK_DIV-1 and wraps. tick is internal, high while cnt==TICK_DIV-1.
//  - On a tick edge with remain_time>1: remain_time decrements by 1.
//  - On a tick edge with remain_time==1: advance to the next phase; remain_time loads its duration
//    in the same edge. Each phase therefore lasts exactly duration*TICK_DIV clocks. No idle cycle.
//  - Duration inputs are sampled only at the transition edge. Input changes mid-phase do not affect
//    the running phase; they apply from the next entry into that phase.
//  - Sampled duration 0 is forced to 1 (a phase is never skipped). 63 is the maximum; no wrap.
//  - Lamps are a pure decode of phase, registered with it (no glitch, same edge):
//    green phases light one green bit on the active road and red on the other road;
//    yellow phases light that road's yellow and the other road's red; all-red states light both reds.
//  - Exactly one lamp per road is active every cycle.
//  - Reset asserted mid-phase overrides everything on that edge. The prescaler restarts from 0.
// CONFIGURATION
//  ALL_RED_EN defined: ALLRED_EW is inserted after EW_YEL and ALLRED_SN after SN_YEL,
//    each lasting ALLRED_TIME ticks, with ew_red=sn_red=1 and all greens/yellows 0.
//  ALL_RED_EN undefined: yellow goes directly to the opposite road's LEFT phase.
//    Phase codes 8/9 are never produced.
// TESTING  (TICK_DIV=4, YELLOW_TIME=3)
//  - Reset release, all times=10 -> EW_LEFT held 40 clks; remain_time 10..1; then phase=1 with remain=10.
//  - All times=10, no ALL_RED_EN -> full cycle repeats every 66 ticks (264 clks);
//    with ALL_RED_EN, ALLRED_TIME=2 -> 70 ticks (280 clks).
//  - Change ew_stra_time 10->20 during EW_LEFT -> EW_STRA lasts 20 ticks.
//    Change it again during EW_STRA -> current phase still ends at 20.
//  - sn_right_time=0 -> SN_RIGHT lasts exactly 1 tick (4 clks), then SN_YEL.
//  - Assert sys_rst_n=0 for 1 clk during SN_STRA -> next edge phase=0, remain=10, sn_red=1;
//    first decrement 4 clks after release.
//  - Every cycle of a long run -> each road has exactly one lamp active; EW and SN are never both non-red.

Source files
------------

// File: rtl/traffic_phase_seq_if.sv
// Phase sequencer bundle: six green durations in, per-road lamps and display value out.
// Latency: none (wires only).
// Backpressure: none; durations are level inputs, lamps are level outputs.
interface traffic_phase_seq_if;
  logic [5:0] ew_left_time;
  logic [5:0] ew_stra_time;
  logic [5:0] ew_right_time;
  logic [5:0] sn_left_time;
  logic [5:0] sn_stra_time;
  logic [5:0] sn_right_time;
  logic [2:0] ew_green;
  logic       ew_yellow;
  logic       ew_red;
  logic [2:0] sn_green;
  logic       sn_yellow;
  logic       sn_red;
  logic [5:0] remain_time;
  logic [3:0] phase;

  // Duration producer / observer side
  modport master (
    output ew_left_time, ew_stra_time, ew_right_time,
    output sn_left_time, sn_stra_time, sn_right_time,
    input  ew_green, ew_yellow, ew_red, sn_green, sn_yellow, sn_red,
    input  remain_time, phase
  );

  // Sequencer side
  modport slave (
    input  ew_left_time, ew_stra_time, ew_right_time,
    input  sn_left_time, sn_stra_time, sn_right_time,
    output ew_green, ew_yellow, ew_red, sn_green, sn_yellow, sn_red,
    output remain_time, phase
  );
endinterface

// File: rtl/traffic_phase_seq.sv
// Intersection phase sequencer: counts each phase down on a divided seconds tick, drives lamps.
// Latency: lamps/phase/remain_time registered; phase changes on the tick edge where remain_time==1.
// Backpressure: none; free-running. Optional ALL_RED_EN inserts all-red clearance after each yellow.
module traffic_phase_seq #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int YELLOW_TIME = 3,
  parameter int RST_TIME    = 10,
  parameter int ALLRED_TIME = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  traffic_phase_seq_if.slave bus
);

  localparam int CW = $clog2(TICK_DIV);

  typedef enum logic [3:0] {
    EW_LEFT   = 4'd0,
    EW_STRA   = 4'd1,
    EW_RIGHT  = 4'd2,
    EW_YEL    = 4'd3,
    SN_LEFT   = 4'd4,
    SN_STRA   = 4'd5,
    SN_RIGHT  = 4'd6,
    SN_YEL    = 4'd7,
    ALLRED_EW = 4'd8,
    ALLRED_SN = 4'd9
  } phase_e;

  typedef struct packed {
    logic [2:0] ew_green;
    logic       ew_yellow;
    logic       ew_red;
    logic [2:0] sn_green;
    logic       sn_yellow;
    logic       sn_red;
  } lamp_t;

  logic [CW-1:0] cnt;
  logic          tick;
  phase_e        state;
  phase_e        nxt_state;
  logic [5:0]    remain;
  logic [5:0]    nxt_raw;
  logic [5:0]    nxt_dur;
  lamp_t         lamps;

  // Lamp decode: exactly one lamp per road, red on any road that is not moving.
  function automatic lamp_t decode(input phase_e p);
    lamp_t l;
    l        = '0;
    l.ew_red = 1'b1;
    l.sn_red = 1'b1;
    case (p)
      EW_LEFT:  begin l.ew_green = 3'b100; l.ew_red = 1'b0; end
      EW_STRA:  begin l.ew_green = 3'b010; l.ew_red = 1'b0; end
      EW_RIGHT: begin l.ew_green = 3'b001; l.ew_red = 1'b0; end
      EW_YEL:   begin l.ew_yellow = 1'b1;  l.ew_red = 1'b0; end
      SN_LEFT:  begin l.sn_green = 3'b100; l.sn_red = 1'b0; end
      SN_STRA:  begin l.sn_green = 3'b010; l.sn_red = 1'b0; end
      SN_RIGHT: begin l.sn_green = 3'b001; l.sn_red = 1'b0; end
      SN_YEL:   begin l.sn_yellow = 1'b1;  l.sn_red = 1'b0; end
      default:  ;
    endcase
    return l;
  endfunction

  assign tick = (cnt == CW'(TICK_DIV - 1));

  // Seconds prescaler; restarts from zero on reset so the first tick is a full period later.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)
      cnt <= '0;
    else if (tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  // Successor phase and its duration, sampled only when the transition actually happens.
  always_comb begin
    nxt_state = EW_LEFT;
    case (state)
      EW_LEFT:   nxt_state = EW_STRA;
      EW_STRA:   nxt_state = EW_RIGHT;
      EW_RIGHT:  nxt_state = EW_YEL;
      SN_LEFT:   nxt_state = SN_STRA;
      SN_STRA:   nxt_state = SN_RIGHT;
      SN_RIGHT:  nxt_state = SN_YEL;
`ifdef ALL_RED_EN
      EW_YEL:    nxt_state = ALLRED_EW;
      ALLRED_EW: nxt_state = SN_LEFT;
      SN_YEL:    nxt_state = ALLRED_SN;
      ALLRED_SN: nxt_state = EW_LEFT;
`else
      EW_YEL:    nxt_state = SN_LEFT;
      SN_YEL:    nxt_state = EW_LEFT;
`endif
      default:   nxt_state = EW_LEFT;
    endcase

    nxt_raw = 6'd1;
    case (nxt_state)
      EW_LEFT:             nxt_raw = bus.ew_left_time;
      EW_STRA:             nxt_raw = bus.ew_stra_time;
      EW_RIGHT:            nxt_raw = bus.ew_right_time;
      SN_LEFT:             nxt_raw = bus.sn_left_time;
      SN_STRA:             nxt_raw = bus.sn_stra_time;
      SN_RIGHT:            nxt_raw = bus.sn_right_time;
      EW_YEL, SN_YEL:      nxt_raw = 6'(YELLOW_TIME);
      ALLRED_EW, ALLRED_SN: nxt_raw = 6'(ALLRED_TIME);
      default:             nxt_raw = 6'd1;
    endcase
    // A zero duration would skip the phase; hold it for one tick instead.
    nxt_dur = (nxt_raw == 6'd0) ? 6'd1 : nxt_raw;
  end

  // Phase FSM: count down on tick, advance and reload on the last tick, lamps follow the phase.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state  <= EW_LEFT;
      remain <= 6'(RST_TIME);
      lamps  <= decode(EW_LEFT);
    end else if (tick) begin
      if (remain > 6'd1) begin
        remain <= remain - 6'd1;
      end else begin
        state  <= nxt_state;
        remain <= nxt_dur;
        lamps  <= decode(nxt_state);
      end
    end
  end

  assign bus.ew_green    = lamps.ew_green;
  assign bus.ew_yellow   = lamps.ew_yellow;
  assign bus.ew_red      = lamps.ew_red;
  assign bus.sn_green    = lamps.sn_green;
  assign bus.sn_yellow   = lamps.sn_yellow;
  assign bus.sn_red      = lamps.sn_red;
  assign bus.remain_time = remain;
  assign bus.phase       = state;

endmodule

// File: tb/tb_traffic_phase_seq.sv
// Bench for traffic_phase_seq: directed scenarios then randomized durations and resets.
// Reference model tracks elapsed clocks per phase and derives remain_time by division.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_traffic_phase_seq;
  localparam int TD = 4;
  localparam int YT = 3;
  localparam int RT = 10;
  localparam int AT = 2;

`ifdef ALL_RED_EN
  localparam int NSEQ = 10;
  localparam int PER  = 280;
  int seq [NSEQ] = '{0, 1, 2, 3, 8, 4, 5, 6, 7, 9};
`else
  localparam int NSEQ = 8;
  localparam int PER  = 264;
  int seq [NSEQ] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  traffic_phase_seq_if bus();

  traffic_phase_seq #(
    .TICK_DIV(TD), .YELLOW_TIME(YT), .RST_TIME(RT), .ALLRED_TIME(AT)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state
  bit m_valid = 0;
  int m_idx, m_el, m_dur;
  int cyc = 0;
  // Observed phase run lengths and cycle period
  int cur_ph = 0, ph_entry = 0, last_entry0 = 0, period = 0;
  int last_len [16];

  function automatic int dur_for(input int ph);
    int d;
    case (ph)
      0: d = bus.ew_left_time;
      1: d = bus.ew_stra_time;
      2: d = bus.ew_right_time;
      4: d = bus.sn_left_time;
      5: d = bus.sn_stra_time;
      6: d = bus.sn_right_time;
      3, 7: d = YT;
      default: d = AT;
    endcase
    return (d == 0) ? 1 : d;
  endfunction

  function automatic logic [9:0] exp_lamps(input int ph);
    logic [2:0] eg, sg;
    logic ey, er, sy, sr;
    eg = 3'b000; sg = 3'b000; ey = 1'b0; sy = 1'b0; er = 1'b1; sr = 1'b1;
    if (ph <= 2) begin eg = 3'b100 >> ph; er = 1'b0; end
    else if (ph == 3) begin ey = 1'b1; er = 1'b0; end
    else if (ph >= 4 && ph <= 6) begin sg = 3'b100 >> (ph - 4); sr = 1'b0; end
    else if (ph == 7) begin sy = 1'b1; sr = 1'b0; end
    return {eg, ey, er, sg, sy, sr};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      m_idx = 0; m_el = 0; m_dur = RT; m_valid = 1;
      cur_ph = 0; ph_entry = cyc; last_entry0 = cyc;
    end else if (m_valid) begin
      m_el++;
      if (m_el == m_dur * TD) begin
        m_idx = (m_idx + 1) % NSEQ;
        m_el  = 0;
        m_dur = dur_for(seq[m_idx]);
      end
      if (int'(bus.phase) != cur_ph) begin
        last_len[cur_ph] = cyc - ph_entry;
        cur_ph = int'(bus.phase);
        ph_entry = cyc;
        if (cur_ph == 0) begin
          period = cyc - last_entry0;
          last_entry0 = cyc;
        end
      end
    end
    if (m_valid) begin
      check("phase", bus.phase, seq[m_idx]);
      check("remain", bus.remain_time, m_dur - m_el / TD);
      check("lamps", {bus.ew_green, bus.ew_yellow, bus.ew_red,
                      bus.sn_green, bus.sn_yellow, bus.sn_red}, exp_lamps(seq[m_idx]));
      check("ew_one_lamp", $countones({bus.ew_green, bus.ew_yellow, bus.ew_red}), 1);
      check("sn_one_lamp", $countones({bus.sn_green, bus.sn_yellow, bus.sn_red}), 1);
      check("both_roads_go", (!bus.ew_red && !bus.sn_red), 0);
    end
  endtask

  task automatic wait_phase(input int ph, input int budget, input string tag);
    int n = 0;
    while (int'(bus.phase) != ph && n < budget) begin
      step();
      n++;
    end
    check(tag, bus.phase, ph);
  endtask

  task automatic set_all(input logic [5:0] v);
    bus.ew_left_time = v; bus.ew_stra_time = v; bus.ew_right_time = v;
    bus.sn_left_time = v; bus.sn_stra_time = v; bus.sn_right_time = v;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) last_len[i] = -1;
    set_all(6'd10);

    // Reset state
    rst_n = 1'b0;
    step();
    check("rst_phase", bus.phase, 0);
    check("rst_remain", bus.remain_time, RT);
    check("rst_lamps", {bus.ew_green, bus.ew_yellow, bus.ew_red,
                        bus.sn_green, bus.sn_yellow, bus.sn_red}, 10'b100_0_0_000_0_1);
    rst_n = 1'b1;

    // First phase length and full-cycle period with all durations 10
    wait_phase(1, 60, "reach_ew_stra");
    check("ew_left_len", last_len[0], RT * TD);
    check("ew_stra_entry_remain", bus.remain_time, 10);
    wait_phase(0, PER + 20, "reach_cycle_wrap");
    check("cycle_period", period, PER);

    // Duration change during EW_LEFT applies to EW_STRA; change during EW_STRA is ignored
    bus.ew_stra_time = 6'd20;
    wait_phase(1, 60, "reach_ew_stra_2");
    bus.ew_stra_time = 6'd5;
    wait_phase(2, 100, "reach_ew_right");
    check("ew_stra_len", last_len[1], 20 * TD);
    bus.ew_stra_time = 6'd10;

    // Zero duration is held for one tick
    bus.sn_right_time = 6'd0;
    wait_phase(7, 600, "reach_sn_yel");
    check("sn_right_len", last_len[6], TD);
    bus.sn_right_time = 6'd10;

    // One-clock reset during SN_STRA
    wait_phase(5, 800, "reach_sn_stra");
    for (int i = 0; i < 7; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_phase", bus.phase, 0);
    check("midrst_remain", bus.remain_time, RT);
    check("midrst_sn_red", bus.sn_red, 1);
    for (int i = 0; i < TD - 1; i++) step();
    check("midrst_hold", bus.remain_time, RT);
    step();
    check("midrst_first_dec", bus.remain_time, RT - 1);

    // Randomized durations and occasional resets
    for (int i = 0; i < 20000; i++) begin
      if ($urandom % 40 == 0) begin
        logic [5:0] v;
        v = ($urandom % 8 == 0) ? 6'd63 : 6'($urandom_range(0, 12));
        case ($urandom % 6)
          0: bus.ew_left_time = v;
          1: bus.ew_stra_time = v;
          2: bus.ew_right_time = v;
          3: bus.sn_left_time = v;
          4: bus.sn_stra_time = v;
          default: bus.sn_right_time = v;
        endcase
      end
      rst_n = ($urandom % 2500 != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
